weight_stream_loader: RTL and testbench

//  Front end of the weight manager's write port: converts the 64-bit AXI-Stream weight feed from DMA into
//  the 72-bit wr_en/wr_data word stream the weight manager consumes in strict order (uram -> bank -> addr).

---
 rtl/weight_stream_loader.sv | 73 +++++++
 tb/tb_weight_stream_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_loader.sv
// weight_stream_loader: packs a 64-bit AXI-Stream weight feed into ordered 72-bit weight-manager writes (9 beats -> 8 words per group).
module weight_stream_loader #(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int GRP_WIDTH  = ADDR_WIDTH + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [GRP_WIDTH-1:0] num_groups,
  input  logic [63:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic                 wr_en,
  output logic [71:0]          wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  localparam int BW = GRP_WIDTH + 4;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [135:0] sbuf, buf_s, buf_n;
  logic [7:0] cnt, cnt_e, cnt_n;
  logic [BW-1:0] beats_left;
  logic emit, hs, last_beat;
  assign emit = cnt >= 8'd72;
  assign cnt_e = emit ? cnt - 8'd72 : cnt;
  assign s_axis_tready = (state == LOAD) && (beats_left != '0) && (cnt_e <= 8'd72);
  assign hs = s_axis_tvalid & s_axis_tready;
  assign last_beat = beats_left == BW'(1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  // the emitted word leaves the bottom while the new beat lands just above the remaining bits
  always_comb begin
    buf_s = emit ? sbuf >> 72 : sbuf;
    buf_n = buf_s;
    if (hs) buf_n[cnt_e +: 64] = s_axis_tdata;
    cnt_n = cnt_e + (hs ? 8'd64 : 8'd0);
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (start ? (num_groups != '0 ? LOAD : DONE) : IDLE)
            : state == LOAD  ? (hs && last_beat ? FLUSH : LOAD)
            : state == FLUSH ? (cnt == 8'd0 ? DONE : FLUSH)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sbuf       <= '0;
      cnt        <= '0;
      beats_left <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      error      <= 1'b0;
    end else begin
      state <= state_n;
      sbuf  <= buf_n;
      cnt   <= cnt_n;
      wr_en <= emit;
      if (emit) wr_data <= sbuf[71:0];
      if (state == IDLE && start) begin
        beats_left <= BW'({num_groups, 3'b000}) + BW'(num_groups);
        error      <= 1'b0;
      end else if (hs) begin
        beats_left <= beats_left - BW'(1);
        if (s_axis_tlast != last_beat) error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_weight_stream_loader.sv
// tb_weight_stream_loader: directed self-checking bench for weight_stream_loader.
module tb_weight_stream_loader;
  localparam int GW = 16;
  logic clk, rst, start, tvalid, tready, tlast, wr_en, busy, done, error;
  logic [GW-1:0] num_groups;
  logic [63:0] tdata;
  logic [71:0] wr_data;
  logic [2303:0] ref_bits;
  logic [71:0] wq[$];
  int wc[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, passed = 0, total = 0, base = 0;

  weight_stream_loader dut (
    .clk(clk), .rst(rst), .start(start), .num_groups(num_groups),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .done(done), .error(error)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back(wr_data);
      wc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [GW-1:0] ng);
    start = 1;
    num_groups = ng;
    tick();
    start = 0;
    base = cyc;
  endtask

  task automatic stream(input int nb_total, input int from, input int upto, input bit gaps,
                        input int bad_last, input int pulse_at);
    int n;
    for (int k = from; k < upto; k++) begin
      if (gaps && $urandom_range(1) == 1) begin
        tvalid = 0;
        tick();
      end
      tvalid = 1;
      tdata = ref_bits[64*k +: 64];
      tlast = (k == nb_total - 1) ^ (k == bad_last);
      start = (k == pulse_at);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!tready && n < 100);
      if (!tready) begin
        total++;
        $error("FAIL tready_timeout observed=0 expected=1 beat=%0d", k);
        $display("%0d/%0d checks passed", passed, total);
        $fatal(1, "stalled");
      end
      tick();
      start = 0;
    end
    tvalid = 0;
    tlast = 0;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (done_cnt != d0) passed++;
    else $error("FAIL done_timeout observed=0 expected=1");
  endtask

  task automatic check_words(input string tag, input int nw);
    chk({tag, "_count"}, 72'(wq.size()), 72'(nw));
    for (int i = 0; i < wq.size() && i < nw; i++) chk({tag, "_word"}, wq[i], ref_bits[72*i +: 72]);
  endtask

  initial begin
    rst = 1; start = 0; num_groups = 0; tdata = 0; tvalid = 0; tlast = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_tready", 72'(tready), 0);
    chk("rst_wr_en", 72'(wr_en), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", 72'(busy), 0);
    chk("rst_done", 72'(done), 0);
    chk("rst_error", 72'(error), 0);
    tick();

    // one group, back-to-back, timing reference
    for (int k = 0; k < 9; k++) ref_bits[64*k +: 64] = 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
    wq.delete(); wc.delete();
    do_start(1);
    chk("t1_busy", 72'(busy), 1);
    stream(9, 0, 9, 0, -1, -1);
    wait_done();
    check_words("t1", 8);
    chk("t1_w0_const", wq.size() > 0 ? wq[0] : 72'hx, 72'h080706050403020100);
    chk("t1_first_cyc", 72'(wc.size() > 0 ? wc[0] - base : -1), 3);
    chk("t1_last_cyc", 72'(wc.size() > 0 ? wc[wc.size()-1] - base : -1), 10);
    chk("t1_done_cyc", 72'(done_cyc - base), 11);
    chk("t1_error", 72'(error), 0);
    tick();
    chk("t1_busy_after", 72'(busy), 0);
    chk("t1_done_after", 72'(done), 0);

    // four groups with random valid gaps
    for (int k = 0; k < 36; k++) ref_bits[64*k +: 64] = {$urandom, $urandom};
    wq.delete(); wc.delete();
    do_start(4);
    stream(36, 0, 36, 1, -1, -1);
    wait_done();
    check_words("t2", 32);
    chk("t2_error", 72'(error), 0);
    tick();

    // early tlast on beat 4
    for (int k = 0; k < 9; k++) ref_bits[64*k +: 64] = {$urandom, $urandom};
    wq.delete(); wc.delete();
    do_start(1);
    stream(9, 0, 4, 0, 4, -1);
    chk("t3_error_before", 72'(error), 0);
    stream(9, 4, 5, 0, 4, -1);
    chk("t3_error_after", 72'(error), 1);
    stream(9, 5, 9, 0, 4, -1);
    wait_done();
    check_words("t3", 8);
    tick();
    chk("t3_error_sticky", 72'(error), 1);

    // zero groups: done only
    wq.delete(); wc.delete();
    do_start(0);
    chk("t4_done", 72'(done), 1);
    chk("t4_busy", 72'(busy), 1);
    chk("t4_error_cleared", 72'(error), 0);
    tick();
    chk("t4_done_low", 72'(done), 0);
    chk("t4_busy_low", 72'(busy), 0);
    repeat (3) tick();
    chk("t4_no_words", 72'(wq.size()), 0);

    // rst after 5 beats of a 2-group load, then a fresh 1-group load
    for (int k = 0; k < 18; k++) ref_bits[64*k +: 64] = {$urandom, $urandom};
    do_start(2);
    stream(18, 0, 5, 0, -1, -1);
    rst = 1;
    tick();
    rst = 0;
    wq.delete(); wc.delete();
    chk("t5_busy_rst", 72'(busy), 0);
    chk("t5_tready_rst", 72'(tready), 0);
    repeat (4) tick();
    chk("t5_no_words_after_rst", 72'(wq.size()), 0);
    for (int k = 0; k < 9; k++) ref_bits[64*k +: 64] = {$urandom, $urandom};
    do_start(1);
    stream(9, 0, 9, 0, -1, -1);
    wait_done();
    check_words("t5", 8);
    tick();

    // start re-pulsed mid-load must be ignored
    for (int k = 0; k < 9; k++) ref_bits[64*k +: 64] = {$urandom, $urandom};
    wq.delete(); wc.delete();
    do_start(1);
    num_groups = 5;
    stream(9, 0, 9, 0, -1, 4);
    wait_done();
    check_words("t6", 8);
    chk("t6_done_cyc", 72'(done_cyc - base), 11);
    repeat (20) tick();
    chk("t6_no_extra_words", 72'(wq.size()), 8);
    chk("t6_busy", 72'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
